// File: rtl/sram_port_arbiter.sv
// Shares one single-port ack-handshaked SRAM between the fetch port and the load/store port.
// Optional ARB_TIMEOUT_EN adds a watchdog that aborts a transaction with no ack after TIMEOUT_CYCLES.
module sram_port_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_inst_o,
    output logic        if_stallreq_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_stallreq_o,
    output logic        bus_ce_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    // Handshake: a port holds its *_ce_i high until its stall request drops; the bus side holds
    // bus_* stable from grant until bus_ack_i, which completes exactly one transaction.
    state_t      state;
    logic [3:0]  starve_cnt;
    logic [31:0] inst_q;
    logic [31:0] data_q;
    logic        grant_mem;
    logic        grant_if;
    logic        abort;
    logic        if_done;
    logic        mem_done;
    logic [31:0] rdata_now;

    assign grant_mem = mem_ce_i && !(if_ce_i && (starve_cnt == 4'(STARVE_LIMIT)));
    assign grant_if  = !grant_mem && if_ce_i;

`ifdef ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // The counter sits at zero in IDLE, so every busy state starts its count fresh.
    assign abort = (state != IDLE) && !bus_ack_i && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset_n || state == IDLE || abort) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end
`else
    logic unused_timeout;

    assign abort          = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    assign bus_err_o = abort;
    assign if_done   = (state == IF_BUSY) && (bus_ack_i || abort);
    assign mem_done  = (state == MEM_BUSY) && (bus_ack_i || abort);
    assign rdata_now = abort ? 32'h0 : bus_rdata_i;

    assign if_inst_o      = if_done ? rdata_now : inst_q;
    assign mem_rdata_o    = (mem_done && !bus_we_o) ? rdata_now : data_q;
    assign if_stallreq_o  = if_ce_i && !if_done;
    assign mem_stallreq_o = mem_ce_i && !mem_done;
    assign dbg_state      = state;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            inst_q      <= '0;
            data_q      <= '0;
            bus_ce_o    <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
        end else begin
            if (!if_ce_i) begin
                starve_cnt <= '0;
            end
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        bus_ce_o    <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_sel_o   <= mem_sel_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= mem_wdata_i;
                        state       <= MEM_BUSY;
                        // Count data grants that overtook a waiting fetch; saturate.
                        if (if_ce_i && starve_cnt != 4'hF) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (grant_if) begin
                        bus_ce_o    <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= 4'hF;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= '0;
                        starve_cnt  <= '0;
                        state       <= IF_BUSY;
                    end
                end
                IF_BUSY: begin
                    if (if_done) begin
                        bus_ce_o <= 1'b0;
                        inst_q   <= rdata_now;
                        state    <= IDLE;
                    end
                end
                MEM_BUSY: begin
                    if (mem_done) begin
                        bus_ce_o <= 1'b0;
                        if (!bus_we_o) begin
                            data_q <= rdata_now;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    bus_ce_o <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: per-cycle vector table plus starvation and watchdog sequences.
module tb_sram_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_inst_o;
    logic        if_stallreq_o;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_stallreq_o;
    logic        bus_ce_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    sram_port_arbiter #(
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .if_ce_i       (if_ce_i),
        .if_addr_i     (if_addr_i),
        .if_inst_o     (if_inst_o),
        .if_stallreq_o (if_stallreq_o),
        .mem_ce_i      (mem_ce_i),
        .mem_we_i      (mem_we_i),
        .mem_sel_i     (mem_sel_i),
        .mem_addr_i    (mem_addr_i),
        .mem_wdata_i   (mem_wdata_i),
        .mem_rdata_o   (mem_rdata_o),
        .mem_stallreq_o(mem_stallreq_o),
        .bus_ce_o      (bus_ce_o),
        .bus_we_o      (bus_we_o),
        .bus_sel_o     (bus_sel_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_rdata_i   (bus_rdata_i),
        .bus_ack_i     (bus_ack_i),
        .bus_err_o     (bus_err_o),
        .dbg_state     (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic        rst;
        logic        if_ce;
        logic [31:0] if_addr;
        logic        mem_ce;
        logic        mem_we;
        logic [3:0]  mem_sel;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] rdata;
        logic        ack;
        logic [1:0]  e_state;
        logic        e_if_stall;
        logic        e_mem_stall;
        logic        e_ce;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_inst;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs[NVEC];
    logic [31:0] exp_q[$];

    function automatic vec_t mk(
        input logic rst, input logic if_ce, input logic [31:0] if_addr,
        input logic mem_ce, input logic mem_we, input logic [3:0] mem_sel,
        input logic [31:0] mem_addr, input logic [31:0] mem_wdata,
        input logic [31:0] rdata, input logic ack,
        input logic [1:0] e_state, input logic e_if_stall, input logic e_mem_stall,
        input logic e_ce, input logic e_we, input logic [3:0] e_sel,
        input logic [31:0] e_addr, input logic [31:0] e_wdata,
        input logic [31:0] e_inst, input logic [31:0] e_rdata);
        vec_t v;
        v.rst = rst; v.if_ce = if_ce; v.if_addr = if_addr;
        v.mem_ce = mem_ce; v.mem_we = mem_we; v.mem_sel = mem_sel;
        v.mem_addr = mem_addr; v.mem_wdata = mem_wdata; v.rdata = rdata; v.ack = ack;
        v.e_state = e_state; v.e_if_stall = e_if_stall; v.e_mem_stall = e_mem_stall;
        v.e_ce = e_ce; v.e_we = e_we; v.e_sel = e_sel; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_inst = e_inst; v.e_rdata = e_rdata;
        return v;
    endfunction

    // Scoreboard compare
    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_idle();
        reset_n = 1'b0; if_ce_i = 1'b0; if_addr_i = '0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
        mem_sel_i = '0; mem_addr_i = '0; mem_wdata_i = '0; bus_rdata_i = '0; bus_ack_i = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        reset_n = v.rst; if_ce_i = v.if_ce; if_addr_i = v.if_addr;
        mem_ce_i = v.mem_ce; mem_we_i = v.mem_we; mem_sel_i = v.mem_sel;
        mem_addr_i = v.mem_addr; mem_wdata_i = v.mem_wdata;
        bus_rdata_i = v.rdata; bus_ack_i = v.ack;
        #1;
        chk("state",      idx, 32'(dbg_state),      32'(v.e_state));
        chk("if_stall",   idx, 32'(if_stallreq_o),  32'(v.e_if_stall));
        chk("mem_stall",  idx, 32'(mem_stallreq_o), 32'(v.e_mem_stall));
        chk("bus_ce",     idx, 32'(bus_ce_o),       32'(v.e_ce));
        chk("bus_we",     idx, 32'(bus_we_o),       32'(v.e_we));
        chk("bus_sel",    idx, 32'(bus_sel_o),      32'(v.e_sel));
        chk("bus_addr",   idx, bus_addr_o,          v.e_addr);
        chk("bus_wdata",  idx, bus_wdata_o,         v.e_wdata);
        chk("if_inst",    idx, if_inst_o,           v.e_inst);
        chk("mem_rdata",  idx, mem_rdata_o,         v.e_rdata);
        chk("bus_err",    idx, 32'(bus_err_o),      32'h0);
        @(negedge clk);
    endtask

    initial begin
        // rst if_ce if_addr mem_ce we sel maddr wdata rdata ack | st ifs ms ce we sel addr wdata inst rdata
        vecs[0]  = mk(0,0,32'h0,  0,0,4'h0,32'h0,32'h0,32'h0,0,         0,0,0,0,0,4'h0,32'h0,32'h0,32'h0,32'h0);
        vecs[1]  = mk(0,1,32'h100,0,0,4'h0,32'h0,32'h0,32'h0,0,         0,1,0,0,0,4'h0,32'h0,32'h0,32'h0,32'h0);
        vecs[2]  = mk(0,1,32'h100,0,0,4'h0,32'h0,32'h0,32'h0,0,         1,1,0,1,0,4'hF,32'h100,32'h0,32'h0,32'h0);
        vecs[3]  = mk(0,1,32'h100,0,0,4'h0,32'h0,32'h0,32'h3C010001,1,  1,0,0,1,0,4'hF,32'h100,32'h0,32'h3C010001,32'h0);
        vecs[4]  = mk(0,0,32'h0,  0,0,4'h0,32'h0,32'h0,32'hFFFFFFFF,1,  0,0,0,0,0,4'hF,32'h100,32'h0,32'h3C010001,32'h0);
        vecs[5]  = mk(0,0,32'h0,  0,0,4'h0,32'h0,32'h0,32'h0,0,         0,0,0,0,0,4'hF,32'h100,32'h0,32'h3C010001,32'h0);
        vecs[6]  = mk(0,1,32'h104,1,0,4'hF,32'h2000,32'h0,32'h0,0,      0,1,1,0,0,4'hF,32'h100,32'h0,32'h3C010001,32'h0);
        vecs[7]  = mk(0,1,32'h104,1,0,4'hF,32'h2000,32'h0,32'h0,0,      2,1,1,1,0,4'hF,32'h2000,32'h0,32'h3C010001,32'h0);
        vecs[8]  = mk(0,1,32'h104,1,0,4'hF,32'h2000,32'h0,32'h11112222,1,2,1,0,1,0,4'hF,32'h2000,32'h0,32'h3C010001,32'h11112222);
        vecs[9]  = mk(0,1,32'h104,0,0,4'h0,32'h0,32'h0,32'h0,0,         0,1,0,0,0,4'hF,32'h2000,32'h0,32'h3C010001,32'h11112222);
        vecs[10] = mk(0,1,32'h104,0,0,4'h0,32'h0,32'h0,32'h0,0,         1,1,0,1,0,4'hF,32'h104,32'h0,32'h3C010001,32'h11112222);
        vecs[11] = mk(0,1,32'h104,0,0,4'h0,32'h0,32'h0,32'h24020005,1,  1,0,0,1,0,4'hF,32'h104,32'h0,32'h24020005,32'h11112222);
        vecs[12] = mk(0,0,32'h0,  0,0,4'h0,32'h0,32'h0,32'h0,0,         0,0,0,0,0,4'hF,32'h104,32'h0,32'h24020005,32'h11112222);
        vecs[13] = mk(0,1,32'h200,0,0,4'h0,32'h0,32'h0,32'h0,0,         0,1,0,0,0,4'hF,32'h104,32'h0,32'h24020005,32'h11112222);
        vecs[14] = mk(0,0,32'h0,  0,0,4'h0,32'h0,32'h0,32'h0,0,         1,0,0,1,0,4'hF,32'h200,32'h0,32'h24020005,32'h11112222);
        vecs[15] = mk(0,0,32'h0,  0,0,4'h0,32'h0,32'h0,32'hAAAA5555,1,  1,0,0,1,0,4'hF,32'h200,32'h0,32'hAAAA5555,32'h11112222);
        vecs[16] = mk(0,0,32'h0,  0,0,4'h0,32'h0,32'h0,32'h0,0,         0,0,0,0,0,4'hF,32'h200,32'h0,32'hAAAA5555,32'h11112222);
        vecs[17] = mk(0,0,32'h0,  1,1,4'h3,32'h3000,32'hDEADBEEF,32'h0,0, 0,0,1,0,0,4'hF,32'h200,32'h0,32'hAAAA5555,32'h11112222);
        vecs[18] = mk(0,0,32'h0,  1,1,4'hF,32'h3FFC,32'h0,32'h0,0,      2,0,1,1,1,4'h3,32'h3000,32'hDEADBEEF,32'hAAAA5555,32'h11112222);
        vecs[19] = mk(0,0,32'h0,  1,1,4'hF,32'h3FFC,32'h0,32'h12345678,0,2,0,1,1,1,4'h3,32'h3000,32'hDEADBEEF,32'hAAAA5555,32'h11112222);
        vecs[20] = mk(0,0,32'h0,  1,1,4'hF,32'h3FFC,32'h0,32'h12345678,1,2,0,0,1,1,4'h3,32'h3000,32'hDEADBEEF,32'hAAAA5555,32'h11112222);
        vecs[21] = mk(0,0,32'h0,  0,0,4'h0,32'h0,32'h0,32'h0,0,         0,0,0,0,1,4'h3,32'h3000,32'hDEADBEEF,32'hAAAA5555,32'h11112222);
        vecs[22] = mk(0,0,32'h0,  1,0,4'hF,32'h5000,32'h0,32'h0,0,      0,0,1,0,1,4'h3,32'h3000,32'hDEADBEEF,32'hAAAA5555,32'h11112222);
        vecs[23] = mk(1,0,32'h0,  1,0,4'hF,32'h5000,32'h0,32'h0,0,      2,0,1,1,0,4'hF,32'h5000,32'h0,32'hAAAA5555,32'h11112222);
        vecs[24] = mk(0,0,32'h0,  0,0,4'h0,32'h0,32'h0,32'h99999999,1,  0,0,0,0,0,4'h0,32'h0,32'h0,32'h0,32'h0);
        vecs[25] = mk(0,0,32'h0,  0,0,4'h0,32'h0,32'h0,32'h0,0,         0,0,0,0,0,4'h0,32'h0,32'h0,32'h0,32'h0);

        drive_idle();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i], i);
        end

        // Starvation: data held with fetch pending; four data grants, then fetch, then data again.
        begin
            int grants;
            int cyc;
            grants = 0;
            cyc = 0;
            for (int k = 0; k < 4; k++) exp_q.push_back(32'h4000);
            exp_q.push_back(32'h300);
            exp_q.push_back(32'h4000);
            while (grants < 6 && cyc < 40) begin
                if_ce_i = 1'b1; if_addr_i = 32'h300;
                mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h4000; mem_wdata_i = '0;
                bus_ack_i = (dbg_state != 2'd0);
                bus_rdata_i = 32'h0BAD0000 + 32'(grants);
                #1;
                if (bus_ce_o && bus_ack_i) begin
                    chk("grant_addr", grants, bus_addr_o, exp_q.pop_front());
                    grants++;
                end
                @(negedge clk);
                cyc++;
            end
            n_checks++;
            if (grants < 6) begin
                n_fail++;
                $display("FAIL starve_grants: got %0d grants, expected 6", grants);
            end
            drive_idle();
            @(negedge clk);
        end

`ifdef ARB_TIMEOUT_EN
        // Watchdog: load with no ack aborts on the 8th busy cycle.
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h6000;
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (k < 8) begin
                chk("err_early", k, 32'(bus_err_o), 32'h0);
            end else begin
                chk("err_pulse", k, 32'(bus_err_o), 32'h1);
                chk("to_stall", k, 32'(mem_stallreq_o), 32'h0);
                chk("to_rdata", k, mem_rdata_o, 32'h0);
            end
            @(negedge clk);
        end
        mem_ce_i = 1'b0;
        #1;
        chk("to_state", 0, 32'(dbg_state), 32'h0);
        chk("to_err_off", 0, 32'(bus_err_o), 32'h0);
        chk("to_ce", 0, 32'(bus_ce_o), 32'h0);
        @(negedge clk);
`endif

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
